// File: rtl/alarm_sequencer_pkg.sv
// Shared state encodings and default timing parameters for the alarm sequencer.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RING    = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam int DEF_RING_TIMEOUT_SEC = 60;
    localparam int DEF_SNOOZE_MIN       = 5;
    localparam int DEF_MAX_SNOOZE       = 3;

endpackage

// File: rtl/alarm_sequencer.sv
// Alarm ring / snooze / auto-timeout / lockout sequencer driving the buzzer.
// Optional build macro ALARM_BEEP_PATTERN_EN gates the 1 s on / 1 s off beep pattern.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | armed or disarmed, waiting for enable && match
// ST_RING    | buzzer on, counting one_sec ticks toward automatic stop
// ST_SNOOZE  | buzzer off, counting one_min ticks toward re-ring
// ST_LOCKOUT | buzzer off, waiting for the matching minute to end
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC,
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_enable,
    input  logic       alarm_match,
    input  logic       one_sec,
    input  logic       one_min,
    input  logic       snooze_button,
    input  logic       stop_button,
    output logic       sound_alarm,
    output logic       alarm_active,
    output logic       snoozing,
    output logic [2:0] snooze_left
);

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_MIN + 1);
    localparam logic [RW-1:0] RING_TC = RW'(RING_TIMEOUT_SEC);
    localparam logic [SW-1:0] SNZ_TC  = SW'(SNOOZE_MIN);
    localparam logic [2:0]    SNZ_MAX = 3'(MAX_SNOOZE);

    state_t        r_state, w_state_nxt;
    logic [RW-1:0] r_ring_cnt, w_ring_cnt_nxt, w_ring_inc;
    logic [SW-1:0] r_snz_cnt, w_snz_cnt_nxt, w_snz_inc;
    logic [2:0]    r_snooze_left, w_snooze_left_nxt;
    logic          r_sound, r_active, r_snoozing;
    logic          w_sound_nxt;
`ifdef ALARM_BEEP_PATTERN_EN
    logic          r_beep_phase, w_beep_phase_nxt;
`endif

    // Counters saturate at their terminal values rather than wrapping.
    assign w_ring_inc = (r_ring_cnt == RING_TC) ? RING_TC : r_ring_cnt + 1'b1;
    assign w_snz_inc  = (r_snz_cnt == SNZ_TC) ? SNZ_TC : r_snz_cnt + 1'b1;

    always_comb begin
        w_state_nxt       = r_state;
        w_ring_cnt_nxt    = r_ring_cnt;
        w_snz_cnt_nxt     = r_snz_cnt;
        w_snooze_left_nxt = r_snooze_left;
`ifdef ALARM_BEEP_PATTERN_EN
        w_beep_phase_nxt  = r_beep_phase;
`endif
        if (!alarm_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (alarm_match) begin
                        w_state_nxt       = ST_RING;
                        w_snooze_left_nxt = SNZ_MAX;
                        w_ring_cnt_nxt    = '0;
`ifdef ALARM_BEEP_PATTERN_EN
                        w_beep_phase_nxt  = 1'b1;
`endif
                    end
                end
                ST_RING: begin
                    if (stop_button) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else if (snooze_button && (r_snooze_left != 3'd0)) begin
                        w_state_nxt       = ST_SNOOZE;
                        w_snooze_left_nxt = r_snooze_left - 3'd1;
                        w_snz_cnt_nxt     = '0;
                    end else if (one_sec) begin
                        w_ring_cnt_nxt = w_ring_inc;
`ifdef ALARM_BEEP_PATTERN_EN
                        w_beep_phase_nxt = ~r_beep_phase;
`endif
                        if (w_ring_inc == RING_TC) w_state_nxt = ST_LOCKOUT;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_button) begin
                        w_state_nxt = ST_LOCKOUT;
                    end else if (one_min) begin
                        w_snz_cnt_nxt = w_snz_inc;
                        if (w_snz_inc == SNZ_TC) begin
                            w_state_nxt    = ST_RING;
                            w_ring_cnt_nxt = '0;
`ifdef ALARM_BEEP_PATTERN_EN
                            w_beep_phase_nxt = 1'b1;
`endif
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (!alarm_match) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the entering edge.
`ifdef ALARM_BEEP_PATTERN_EN
    assign w_sound_nxt = (w_state_nxt == ST_RING) && w_beep_phase_nxt;
`else
    assign w_sound_nxt = (w_state_nxt == ST_RING);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_ring_cnt    <= '0;
            r_snz_cnt     <= '0;
            r_snooze_left <= SNZ_MAX;
            r_sound       <= 1'b0;
            r_active      <= 1'b0;
            r_snoozing    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ring_cnt    <= w_ring_cnt_nxt;
            r_snz_cnt     <= w_snz_cnt_nxt;
            r_snooze_left <= w_snooze_left_nxt;
            r_sound       <= w_sound_nxt;
            r_active      <= (w_state_nxt == ST_RING) || (w_state_nxt == ST_SNOOZE);
            r_snoozing    <= (w_state_nxt == ST_SNOOZE);
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_beep_phase <= 1'b0;
        else        r_beep_phase <= w_beep_phase_nxt;
    end
`endif

    assign sound_alarm  = r_sound;
    assign alarm_active = r_active;
    assign snoozing     = r_snoozing;
    assign snooze_left  = r_snooze_left;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
module tb_alarm_sequencer;

    localparam int RT = 4;
    localparam int SM = 2;
    localparam int MS = 2;
`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_LOCK = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alarm_enable = 1'b0, alarm_match = 1'b0;
    logic       one_sec = 1'b0, one_min = 1'b0;
    logic       snooze_button = 1'b0, stop_button = 1'b0;
    logic       sound_alarm, alarm_active, snoozing;
    logic [2:0] snooze_left;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode plus remaining-time down counts and ticks heard this ring.
    int m_mode = M_IDLE;
    int m_sec_left = 0;
    int m_min_left = 0;
    int m_snz = MS;
    int m_ticks = 0;

    bit beep_seq[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit steady_seq[4] = '{1'b1, 1'b1, 1'b1, 1'b1};

    alarm_sequencer #(
        .RING_TIMEOUT_SEC(RT),
        .SNOOZE_MIN      (SM),
        .MAX_SNOOZE      (MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .alarm_enable (alarm_enable),
        .alarm_match  (alarm_match),
        .one_sec      (one_sec),
        .one_min      (one_min),
        .snooze_button(snooze_button),
        .stop_button  (stop_button),
        .sound_alarm  (sound_alarm),
        .alarm_active (alarm_active),
        .snoozing     (snoozing),
        .snooze_left  (snooze_left)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode  = M_IDLE;
        m_snz   = MS;
        m_ticks = 0;
    endfunction

    function automatic void start_ring();
        m_mode     = M_RING;
        m_sec_left = RT;
        m_ticks    = 0;
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
        end else if (!alarm_enable) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (alarm_match) begin
                m_snz = MS;
                start_ring();
            end
        end else if (m_mode == M_RING) begin
            if (stop_button) m_mode = M_LOCK;
            else if (snooze_button && m_snz > 0) begin
                m_mode     = M_SNOOZE;
                m_snz      = m_snz - 1;
                m_min_left = SM;
            end else if (one_sec) begin
                m_ticks    = m_ticks + 1;
                m_sec_left = m_sec_left - 1;
                if (m_sec_left == 0) m_mode = M_LOCK;
            end
        end else if (m_mode == M_SNOOZE) begin
            if (stop_button) m_mode = M_LOCK;
            else if (one_min) begin
                m_min_left = m_min_left - 1;
                if (m_min_left == 0) start_ring();
            end
        end else begin
            if (!alarm_match) m_mode = M_IDLE;
        end
    endfunction

    task automatic check_model();
        bit e_snd, e_act, e_snz;
        e_snd = (m_mode == M_RING) && (!BEEP || (m_ticks % 2 == 0));
        e_act = (m_mode == M_RING) || (m_mode == M_SNOOZE);
        e_snz = (m_mode == M_SNOOZE);
        n_vec++;
        if (sound_alarm !== e_snd || alarm_active !== e_act || snoozing !== e_snz ||
            snooze_left !== 3'(m_snz)) begin
            n_err++;
            $display("FAIL model t=%0t got snd=%0b act=%0b snz=%0b left=%0d want snd=%0b act=%0b snz=%0b left=%0d",
                     $time, sound_alarm, alarm_active, snoozing, snooze_left, e_snd, e_act, e_snz, m_snz);
        end
    endtask

    task automatic check_lit(input string name, input logic [2:0] act, input int exp);
        n_vec++;
        if (act !== 3'(exp)) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
        one_sec = 1'b0;
        one_min = 1'b0;
        snooze_button = 1'b0;
        stop_button = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_lit("rst_sound", {2'b0, sound_alarm}, 0);
        check_lit("rst_active", {2'b0, alarm_active}, 0);
        check_lit("rst_snoozing", {2'b0, snoozing}, 0);
        check_lit("rst_left", snooze_left, 2);
        reset = 1'b1;
        model_reset();

        // Ring then auto-timeout, lockout until match falls.
        alarm_enable = 1'b1;
        alarm_match  = 1'b1;
        step();
        check_lit("t1_ring", {2'b0, sound_alarm}, 1);
        for (int k = 1; k <= 3; k++) begin
            one_sec = 1'b1;
            step();
            check_lit("t1_tick", {2'b0, sound_alarm}, BEEP ? int'(beep_seq[k]) : int'(steady_seq[k]));
        end
        one_sec = 1'b1;
        step();
        check_lit("t1_timeout_snd", {2'b0, sound_alarm}, 0);
        check_lit("t1_timeout_act", {2'b0, alarm_active}, 0);
        repeat (3) step();
        check_lit("t1_lockout", {2'b0, sound_alarm}, 0);
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        step();
        check_lit("t1_rering", {2'b0, sound_alarm}, 1);

        // Snooze sequence.
        snooze_button = 1'b1;
        step();
        check_lit("t2_snoozing", {2'b0, snoozing}, 1);
        check_lit("t2_left1", snooze_left, 1);
        check_lit("t2_quiet", {2'b0, sound_alarm}, 0);
        snooze_button = 1'b1;
        step();
        check_lit("t2_snz_ignored", snooze_left, 1);
        one_min = 1'b1; step();
        one_min = 1'b1; step();
        check_lit("t2_reringing", {2'b0, sound_alarm}, 1);
        check_lit("t2_not_snoozing", {2'b0, snoozing}, 0);
        snooze_button = 1'b1;
        step();
        check_lit("t2_left0", snooze_left, 0);
        one_min = 1'b1; step();
        one_min = 1'b1; step();
        snooze_button = 1'b1;
        step();
        check_lit("t2_third_ignored", {2'b0, sound_alarm}, 1);
        check_lit("t2_third_left", snooze_left, 0);

        // Stop + snooze together, then lockout while match held.
        alarm_enable = 1'b0; step();
        alarm_enable = 1'b1; step();
        check_lit("t3_ring", snooze_left, 2);
        stop_button = 1'b1;
        snooze_button = 1'b1;
        step();
        check_lit("t3_stop_active", {2'b0, alarm_active}, 0);
        check_lit("t3_stop_left", snooze_left, 2);
        repeat (100) step();
        check_lit("t4_held_quiet", {2'b0, sound_alarm}, 0);
        alarm_match = 1'b0; step();
        alarm_match = 1'b1; step();
        check_lit("t4_rering", {2'b0, sound_alarm}, 1);

        // Drop enable in snooze, then async reset mid-ring.
        snooze_button = 1'b1; step();
        alarm_enable = 1'b0; step();
        check_lit("t5_drop_active", {2'b0, alarm_active}, 0);
        check_lit("t5_drop_snoozing", {2'b0, snoozing}, 0);
        alarm_enable = 1'b1; step();
        snooze_button = 1'b1; step();
        one_min = 1'b1; step();
        one_min = 1'b1; step();
        check_lit("t5_ring_left", snooze_left, 1);
        #2 reset = 1'b0;
        #1;
        check_lit("t5_rst_sound", {2'b0, sound_alarm}, 0);
        check_lit("t5_rst_active", {2'b0, alarm_active}, 0);
        check_lit("t5_rst_left", snooze_left, 2);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 29) == 0) alarm_match = ~alarm_match;
            if ($urandom_range(0, 149) == 0) alarm_enable = 1'b0;
            else if (!alarm_enable && $urandom_range(0, 9) == 0) alarm_enable = 1'b1;
            one_sec       = ($urandom_range(0, 3) == 0);
            one_min       = ($urandom_range(0, 5) == 0);
            snooze_button = ($urandom_range(0, 11) == 0);
            stop_button   = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
